// File: rtl/pci_pkg.sv
// Shared PCI definitions: arbiter state encoding, default grant timeout and
// the active-low signal levels used on the REQ#/GNT#/FRAME#/IRDY# pins.
package pci_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    localparam int GNT_TIMEOUT_DEFAULT = 16;

    // PCI sideband and control pins are active-low
    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin next-owner picker. Takes an active-high request vector and the
// index of the last grant holder; returns the first requester found starting
// at last_owner+1 and wrapping through 0. Purely combinational.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_owner,
    output logic         valid,
    output logic [W-1:0] index
);

    int cand;

    // Walk the ring once, starting just past the last owner; first hit wins
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last_owner) + i) % N;
            if (!valid && req[cand[W-1:0]]) begin
                valid = 1'b1;
                index = cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// PCI bus arbiter: round-robin REQ#/GNT# arbitration over NUM_MASTERS devices,
// with an idle-grant timeout and a mandatory one-clock turnaround between
// grants. Optional bus parking on the last owner is enabled by defining
// PCI_ARB_PARK_EN; the default build leaves all GNT# high when idle.
//
// Handshake: a master requests by holding REQ[i] low; the arbiter answers by
// driving GNT[i] low (registered, at most one low bit). The grant stays until
// the master drops REQ before starting, the idle timeout expires, or the
// transaction it started (FRAME/IRDY) completes; GNT is then all-high for
// exactly one clock before any new grant.
module pci_arbiter
    import pci_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEFAULT
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_MASTERS-1:0]         REQ,
    input  logic                           FRAME,
    input  logic                           IRDY,
    output logic [NUM_MASTERS-1:0]         GNT,
    output logic [$clog2(NUM_MASTERS)-1:0] OWNER,
    output logic                           BUS_BUSY,
    output logic [1:0]                     state_dbg
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(GNT_TIMEOUT + 1);
    localparam logic [NUM_MASTERS-1:0] ALL_HIGH = {NUM_MASTERS{DEASSERTED}};

    arb_state_t      state;
    logic [OW-1:0]   last_owner;
    logic [CW-1:0]   tmo_cnt;
    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic            bus_idle;
    logic            start_grant;
    logic            park_break;

    // Grant vector with only the given master's GNT# low
    function automatic logic [NUM_MASTERS-1:0] gnt_for(input logic [OW-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v      = ALL_HIGH;
        v[idx] = ASSERTED;
        return v;
    endfunction

    assign bus_idle  = (FRAME == DEASSERTED) && (IRDY == DEASSERTED);
    assign state_dbg = state;

    rr_pick #(
        .N (NUM_MASTERS),
        .W (OW)
    ) u_rr_pick (
        .req        (~REQ),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    // Decide whether this edge starts a new grant; the closing edge of TURN
    // doubles as an arbitration edge so grants are separated by one clock only
    always_comb begin
        start_grant = 1'b0;
        park_break  = 1'b0;
        if (bus_idle && pick_valid) begin
            if (state == TURN) begin
                start_grant = 1'b1;
            end else if (state == IDLE) begin
`ifdef PCI_ARB_PARK_EN
                // Parked on someone else: withdraw the park and turn around first
                if (GNT != ALL_HIGH && pick_idx != last_owner) begin
                    park_break = 1'b1;
                end else begin
                    start_grant = 1'b1;
                end
`else
                start_grant = 1'b1;
`endif
            end
        end
    end

    // Arbiter FSM with registered GNT/OWNER/BUS_BUSY
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            GNT        <= ALL_HIGH;
            OWNER      <= '0;
            BUS_BUSY   <= 1'b0;
            tmo_cnt    <= '0;
            last_owner <= OW'(NUM_MASTERS - 1);
        end else begin
            BUS_BUSY <= !bus_idle;
            if (start_grant) begin
                GNT        <= gnt_for(pick_idx);
                OWNER      <= pick_idx;
                last_owner <= pick_idx;
                tmo_cnt    <= '0;
                state      <= GRANT;
            end else begin
                case (state)
                    IDLE: begin
                        if (park_break) begin
                            GNT   <= ALL_HIGH;
                            state <= TURN;
                        end else if (bus_idle) begin
`ifdef PCI_ARB_PARK_EN
                            GNT   <= gnt_for(last_owner);
                            OWNER <= last_owner;
`else
                            GNT   <= ALL_HIGH;
`endif
                        end
                    end
                    GRANT: begin
                        if (FRAME == ASSERTED) begin
                            state <= BUSY;
                        end else if (REQ[OWNER] == DEASSERTED) begin
                            GNT   <= ALL_HIGH;
                            state <= TURN;
                        end else if (IRDY == DEASSERTED) begin
                            // Bus fully idle this clock: count toward timeout
                            if (tmo_cnt == CW'(GNT_TIMEOUT - 1)) begin
                                GNT   <= ALL_HIGH;
                                state <= TURN;
                            end else begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                            end
                        end else begin
                            tmo_cnt <= '0;
                        end
                    end
                    BUSY: begin
                        if (bus_idle) begin
                            GNT   <= ALL_HIGH;
                            state <= TURN;
                        end
                    end
                    TURN: begin
                        GNT   <= ALL_HIGH;
                        state <= IDLE;
                    end
                    default: begin
                        GNT   <= ALL_HIGH;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed testbench for pci_arbiter (4 masters, 16-clock timeout).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_pci_arbiter;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_TURN  = 2'd3;

`ifdef PCI_ARB_PARK_EN
    localparam logic [3:0] PARK_GNT = 4'b0111;
`else
    localparam logic [3:0] PARK_GNT = 4'b1111;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] REQ;
    logic       FRAME;
    logic       IRDY;
    logic [3:0] GNT;
    logic [1:0] OWNER;
    logic       BUS_BUSY;
    logic [1:0] state_dbg;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_g;

    // clock / reset
    always #5 CLK = ~CLK;

    pci_arbiter #(
        .NUM_MASTERS (4),
        .GNT_TIMEOUT (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .FRAME     (FRAME),
        .IRDY      (IRDY),
        .GNT       (GNT),
        .OWNER     (OWNER),
        .BUS_BUSY  (BUS_BUSY),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] req_v);
        RST   = 1'b0;
        REQ   = 4'b1111;
        FRAME = 1'b1;
        IRDY  = 1'b1;
        step();
        step();
        REQ = req_v;
        RST = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST   = 1'b0;
        REQ   = 4'b1111;
        FRAME = 1'b1;
        IRDY  = 1'b1;
        #12;
        check("rst_gnt", GNT, 4'b1111);
        check("rst_owner", OWNER, 0);
        check("rst_busy", BUS_BUSY, 0);
        check("rst_state", state_dbg, S_IDLE);

        // single request from master 0 right after reset
        step();
        REQ = 4'b1110;
        RST = 1'b1;
        step();
        check("first_gnt", GNT, 4'b1110);
        check("first_owner", OWNER, 0);
        check("first_state", state_dbg, S_GRANT);
        REQ = 4'b1111;
        step();
        check("drop_req_gnt", GNT, 4'b1111);
        check("drop_req_state", state_dbg, S_TURN);
        step();
        check("back_idle_state", state_dbg, S_IDLE);
        check("back_idle_gnt", GNT, 4'b1111);

        // all masters requesting: four full transactions in round-robin order
        do_reset(4'b0000);
        exp_q = {4'b1110, 4'b1101, 4'b1011, 4'b0111};
        step();
        for (int i = 0; i < 4; i++) begin
            exp_g = exp_q.pop_front();
            check("rr_gnt", GNT, exp_g);
            check("rr_owner", OWNER, i);
            FRAME = 1'b0;
            step();
            check("rr_busy_gnt", GNT, exp_g);
            check("rr_busy_state", state_dbg, S_BUSY);
            check("rr_bus_busy", BUS_BUSY, 1);
            FRAME = 1'b1;
            IRDY  = 1'b0;
            step();
            check("rr_irdy_gnt", GNT, exp_g);
            IRDY = 1'b1;
            step();
            check("rr_turn_gnt", GNT, 4'b1111);
            check("rr_turn_state", state_dbg, S_TURN);
            check("rr_turn_bus_busy", BUS_BUSY, 0);
            if (i == 3) REQ = 4'b1111;
            step();
        end
        // master 3 done, nobody requesting
        check("after_m3_state", state_dbg, S_IDLE);
        check("after_m3_gnt", GNT, 4'b1111);
        step();
        check("park_gnt", GNT, PARK_GNT);
        step();
        check("park_hold_gnt", GNT, PARK_GNT);

        // grant timeout on master 1, master 2 joins mid-grant
        do_reset(4'b1101);
        step();
        check("tmo_grant", GNT, 4'b1101);
        repeat (4) step();
        REQ = 4'b1001;
        step();
        check("nonowner_req_gnt", GNT, 4'b1101);
        repeat (10) step();
        check("tmo_edge16_gnt", GNT, 4'b1101);
        step();
        check("tmo_release_gnt", GNT, 4'b1111);
        check("tmo_release_state", state_dbg, S_TURN);
        check("tmo_release_owner", OWNER, 1);
        step();
        check("tmo_next_gnt", GNT, 4'b1011);
        check("tmo_next_owner", OWNER, 2);

        // master 2 busy, master 0 requests mid-transaction
        FRAME = 1'b0;
        REQ   = 4'b1010;
        step();
        check("m2_busy_gnt", GNT, 4'b1011);
        check("m2_busy_state", state_dbg, S_BUSY);
        FRAME = 1'b1;
        IRDY  = 1'b0;
        step();
        check("m2_irdy_gnt", GNT, 4'b1011);
        IRDY = 1'b1;
        step();
        check("m2_turn_gnt", GNT, 4'b1111);
        check("m2_turn_state", state_dbg, S_TURN);
        step();
        check("m0_after_turn_gnt", GNT, 4'b1110);
        check("m0_after_turn_owner", OWNER, 0);

        // asynchronous reset mid-transaction
        do_reset(4'b1011);
        step();
        check("pre_rst_gnt", GNT, 4'b1011);
        FRAME = 1'b0;
        step();
        check("pre_rst_state", state_dbg, S_BUSY);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_gnt", GNT, 4'b1111);
        check("async_rst_state", state_dbg, S_IDLE);
        FRAME = 1'b1;
        RST   = 1'b1;
        step();
        check("first_after_rst_gnt", GNT, 4'b1011);

        // foreign transaction on the bus holds the arbiter in IDLE
        do_reset(4'b1111);
        FRAME = 1'b0;
        REQ   = 4'b1110;
        step();
        check("ext_busy_state", state_dbg, S_IDLE);
        check("ext_busy_gnt", GNT, 4'b1111);
        check("ext_busy_flag", BUS_BUSY, 1);
        FRAME = 1'b1;
        step();
        check("ext_done_gnt", GNT, 4'b1110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
